// File: rtl/conv_layer_engine.sv
// conv_layer_engine: LeNet first-layer 5x5 valid convolution (32x32 image -> 6x28x28 map) over a word-addressed DRAM
// Ports:
//   clk, srst                        clock, synchronous active-high reset
//   enable                           start pulse, honoured only in IDLE and DONE
//   data_in                          DRAM read data, valid the cycle after a read request
//   addr_in, dram_en_rd              DRAM read address and request
//   addr_out, data_out, dram_en_wr   DRAM write address, data and strobe
//   done                             layer complete, held until the next enable or srst
// Build option: RELU_EN clamps negative results to zero on write.
module conv_layer_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int FRAC_BITS  = 16,
    parameter int IN_BASE    = 0,
    parameter int W_BASE     = 1024,
    parameter int OUT_BASE   = 4096
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr,
    output logic                  done
);
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int ACC_W = PW + 8;
    localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {IDLE, LOAD_W, FILL, SHIFT, CALC, DONE} state_t;

    state_t                       st;
    logic signed [DATA_WIDTH-1:0] wf [156];
    logic signed [DATA_WIDTH-1:0] win [25];
    logic [7:0]                   cnt, rd_tag, cap_tag;
    logic                         rd_w, cap_v, cap_w;
    logic [2:0]                   kr, kc, k;
    logic [4:0]                   r, c;
    logic signed [ACC_W-1:0]      acc, sh;
    logic [DATA_WIDTH-1:0]        sat, res;

    // One output channel per cycle: full 25-tap dot product plus scaled bias.
    always_comb begin
        acc = ACC_W'(wf[8'(150 + int'(k))]) <<< FRAC_BITS;
        for (int i = 0; i < 25; i++)
            acc = acc + ACC_W'(PW'(win[5'(i)]) * PW'(wf[8'(int'(k) * 25 + i)]));
        sh = acc >>> FRAC_BITS;
        sat = sh > SMAX ? SMAX[DATA_WIDTH-1:0] : sh < SMIN ? SMIN[DATA_WIDTH-1:0] : sh[DATA_WIDTH-1:0];
`ifdef RELU_EN
        res = sat[DATA_WIDTH-1] ? '0 : sat;
`else
        res = sat;
`endif
    end

    // rd_tag travels with each request; cap_* is that tag one cycle later,
    // aligned with the returning data_in word.
    always_ff @(posedge clk) begin
        if (srst) begin
            st <= IDLE;
            {data_out, addr_in, addr_out, dram_en_rd, dram_en_wr, done} <= '0;
            {cnt, rd_tag, cap_tag, rd_w, cap_v, cap_w, kr, kc, k, r, c} <= '0;
            for (int i = 0; i < 156; i++) wf[i] <= '0;
            for (int i = 0; i < 25; i++) win[i] <= '0;
        end else begin
            dram_en_rd <= 1'b0;
            dram_en_wr <= 1'b0;
            cap_v <= dram_en_rd;
            cap_w <= rd_w;
            cap_tag <= rd_tag;
            if (cap_v && cap_w) wf[cap_tag] <= data_in;
            if (cap_v && !cap_w) win[cap_tag[4:0]] <= data_in;
            case (st)
                IDLE: if (enable) begin
                    st <= LOAD_W;
                    cnt <= '0;
                    done <= 1'b0;
                end
                // Leave a phase once the last request has left the ports; its
                // data is captured on the same edge as the state change.
                LOAD_W: if (cnt < 8'd156) begin
                    dram_en_rd <= 1'b1;
                    addr_in <= ADDR_WIDTH'(W_BASE + int'(cnt));
                    rd_w <= 1'b1;
                    rd_tag <= cnt;
                    cnt <= cnt + 8'd1;
                end else if (!dram_en_rd) begin
                    st <= FILL;
                    {cnt, kr, kc, r, c} <= '0;
                end
                FILL: if (cnt < 8'd25) begin
                    dram_en_rd <= 1'b1;
                    addr_in <= ADDR_WIDTH'(IN_BASE + (int'(r) + int'(kr)) * 32 + int'(kc));
                    rd_w <= 1'b0;
                    rd_tag <= cnt;
                    cnt <= cnt + 8'd1;
                    kc <= kc == 3'd4 ? 3'd0 : kc + 3'd1;
                    kr <= kc == 3'd4 ? kr + 3'd1 : kr;
                end else if (!dram_en_rd) begin
                    st <= CALC;
                    k <= '0;
                end
                // c already points at the new column, so the fresh column is c+4.
                SHIFT: if (cnt < 8'd5) begin
                    if (cnt == 8'd0)
                        for (int i = 0; i < 24; i++)
                            if (i % 5 != 4) win[5'(i)] <= win[5'(i + 1)];
                    dram_en_rd <= 1'b1;
                    addr_in <= ADDR_WIDTH'(IN_BASE + (int'(r) + int'(cnt)) * 32 + int'(c) + 4);
                    rd_w <= 1'b0;
                    rd_tag <= cnt * 8'd5 + 8'd4;
                    cnt <= cnt + 8'd1;
                end else if (!dram_en_rd) begin
                    st <= CALC;
                    k <= '0;
                end
                CALC: begin
                    dram_en_wr <= 1'b1;
                    addr_out <= ADDR_WIDTH'(OUT_BASE + int'(k) * 784 + int'(r) * 28 + int'(c));
                    data_out <= res;
                    k <= k + 3'd1;
                    if (k == 3'd5) begin
                        {cnt, kr, kc} <= '0;
                        if (c < 5'd27) begin
                            st <= SHIFT;
                            c <= c + 5'd1;
                        end else if (r < 5'd27) begin
                            st <= FILL;
                            r <= r + 5'd1;
                            c <= '0;
                        end else
                            st <= DONE;
                    end
                end
                DONE: begin
                    done <= !enable;
                    if (enable) begin
                        st <= LOAD_W;
                        cnt <= '0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_layer_engine.sv
// tb_conv_layer_engine: randomized self-checking bench for conv_layer_engine against a behavioural convolution model
module tb_conv_layer_engine;
    localparam int W_BASE   = 1024;
    localparam int OUT_BASE = 4096;
    localparam int NOUT     = 4704;
`ifdef RELU_EN
    localparam logic [31:0] NEG_ONE = 32'h0000_0000;
    localparam logic [31:0] NEG_SAT = 32'h0000_0000;
`else
    localparam logic [31:0] NEG_ONE = 32'hFFE7_0000;
    localparam logic [31:0] NEG_SAT = 32'h8000_0000;
`endif

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic [17:0] addr_in, addr_out;
    logic        dram_en_rd, dram_en_wr, done;
    logic [31:0] img [1024];
    logic [31:0] wt [156];
    logic [31:0] seen [NOUT];
    int total = 0;
    int bad = 0;
    int wn = 0;
    int mr, mc, mk, cyc;

    conv_layer_engine dut (
        .clk(clk), .srst(srst), .enable(enable), .data_in(data_in), .data_out(data_out),
        .addr_in(addr_in), .addr_out(addr_out), .dram_en_rd(dram_en_rd),
        .dram_en_wr(dram_en_wr), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Output (k,r,c) straight from the definition of a valid 2-D convolution.
    function automatic logic [31:0] ref_out(input int k, input int r, input int c);
        logic signed [79:0] a;
        logic [31:0] v;
        a = $signed(wt[150 + k]);
        a = a <<< 16;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                a += longint'($signed(img[(r + i) * 32 + c + j])) * longint'($signed(wt[k * 25 + i * 5 + j]));
        a = a >>> 16;
        if (a > 80'sh7FFF_FFFF) v = 32'h7FFF_FFFF;
        else if (a < -80'sh8000_0000) v = 32'h8000_0000;
        else v = a[31:0];
`ifdef RELU_EN
        if (v[31]) v = 32'h0;
`endif
        return v;
    endfunction

    function automatic logic [31:0] rnd(input int span);
        return 32'($urandom_range(0, 2 * span)) - 32'(span);
    endfunction

    function automatic int oi(input int k, input int r, input int c);
        return k * 784 + r * 28 + c;
    endfunction

    task automatic rand_chan(input int k, input int ws, input int bs);
        for (int i = 0; i < 25; i++) wt[k * 25 + i] = rnd(ws);
        wt[150 + k] = rnd(bs);
    endtask

    // DRAM: one-cycle read latency, image and weight regions only.
    always @(posedge clk)
        if (dram_en_rd)
            data_in <= addr_in < 18'd1024 ? img[addr_in[9:0]]
                     : (addr_in >= 18'(W_BASE) && addr_in < 18'(W_BASE + 156)) ? wt[8'(addr_in - 18'(W_BASE))]
                     : 32'hBAD0_BAD0;

    // Writes must arrive in k, c, r order, each with the model's value.
    always @(negedge clk)
        if (dram_en_wr) begin
            if (wn < NOUT) begin
                mr = wn / 168;
                mc = (wn % 168) / 6;
                mk = wn % 6;
                check("wr_addr", 32'(addr_out), 32'(OUT_BASE + oi(mk, mr, mc)));
                check("wr_data", data_out, ref_out(mk, mr, mc));
                seen[oi(mk, mr, mc)] = data_out;
            end else
                check("extra_write", {31'b0, dram_en_wr}, 32'h0);
            wn++;
        end

    task automatic run_layer(input int pulse_every);
        wn = 0;
        @(negedge clk) enable = 1'b1;
        @(negedge clk) enable = 1'b0;
        check("done_clear", {31'b0, done}, 32'h0);
        cyc = 1;
        while (!done && cyc < 12000) begin
            @(negedge clk);
            cyc++;
            enable = pulse_every != 0 && cyc % pulse_every == 0;
        end
        enable = 1'b0;
        check("done_in_time", {31'b0, done}, 32'h1);
        check("write_count", wn, NOUT);
    endtask

    task automatic quiet(input string tag, input int n);
        int s = 0;
        repeat (n) begin
            @(negedge clk);
            s += int'(dram_en_rd) + int'(dram_en_wr);
        end
        check(tag, s, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dram_en_rd", {31'b0, dram_en_rd}, 32'h0);
        check("rst_dram_en_wr", {31'b0, dram_en_wr}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_addr_in", 32'(addr_in), 32'h0);
        check("rst_addr_out", 32'(addr_out), 32'h0);
        check("rst_data_out", data_out, 32'h0);
        srst = 1'b0;

        for (int i = 0; i < 1024; i++) img[i] = 32'h0001_0000;
        for (int i = 0; i < 25; i++) begin
            wt[i] = 32'h0001_0000;
            wt[25 + i] = 32'hFFFF_0000;
            for (int k = 2; k < 6; k++) wt[k * 25 + i] = 32'h0;
        end
        for (int k = 0; k < 6; k++) wt[150 + k] = k < 2 ? 32'h0 : 32'(k) << 16;
        run_layer(0);
        check("ones_ch0", seen[oi(0, 0, 0)], 32'h0019_0000);
        check("ones_ch0_last", seen[oi(0, 27, 27)], 32'h0019_0000);
        check("neg_ones_ch1", seen[oi(1, 13, 7)], NEG_ONE);
        check("bias_ch2", seen[oi(2, 0, 27)], 32'h0002_0000);
        check("bias_ch5", seen[oi(5, 20, 3)], 32'h0005_0000);

        for (int i = 0; i < 1024; i++) img[i] = 32'(i) << 16;
        for (int i = 0; i < 25; i++) wt[i] = i == 12 ? 32'h0001_0000 : 32'h0;
        wt[150] = 32'h0;
        for (int k = 1; k < 6; k++) rand_chan(k, 32'h8000, 32'h20000);
        run_layer(0);
        check("ramp_ch0_first", seen[oi(0, 0, 0)], 32'h0042_0000);
        check("ramp_ch0_last", seen[oi(0, 27, 27)], 32'h03BD_0000);

        for (int i = 0; i < 1024; i++) img[i] = 32'h7FFF_FFFF;
        for (int i = 0; i < 25; i++) begin
            wt[i] = 32'h7FFF_FFFF;
            wt[25 + i] = 32'h8000_0000;
        end
        wt[150] = 32'h0;
        wt[151] = 32'h0;
        for (int k = 2; k < 6; k++) rand_chan(k, 32'h10000, 32'h40000);
        run_layer(0);
        check("sat_pos", seen[oi(0, 9, 9)], 32'h7FFF_FFFF);
        check("sat_neg", seen[oi(1, 9, 9)], NEG_SAT);

        for (int i = 0; i < 1024; i++) img[i] = rnd(32'h40000);
        for (int k = 0; k < 6; k++) rand_chan(k, 32'h10000, 32'h80000);
        run_layer(2999);
        quiet("post_done_strobes", 25);
        check("done_hold", {31'b0, done}, 32'h1);

        wn = 0;
        @(negedge clk) enable = 1'b1;
        @(negedge clk) enable = 1'b0;
        cyc = 0;
        while (wn < 40 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_in_calc", {31'b0, dram_en_wr}, 32'h1);
        srst = 1'b1;
        @(negedge clk);
        check("abort_wr", {31'b0, dram_en_wr}, 32'h0);
        check("abort_rd", {31'b0, dram_en_rd}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        srst = 1'b0;
        quiet("abort_quiet", 30);
        check("abort_idle_done", {31'b0, done}, 32'h0);

        for (int i = 0; i < 1024; i++) img[i] = rnd(32'h20000);
        for (int k = 0; k < 6; k++) rand_chan(k, 32'h20000, 32'h40000);
        run_layer(0);
        quiet("fresh_done_strobes", 10);
        run_layer(0);
        quiet("rerun_done_strobes", 10);
        check("rerun_done_hold", {31'b0, done}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
